demux_rr_sched: RTL
===================

# demux_rr_sched

Round-robin scheduler for the `demux` datapath. It takes one WIRE-bit valid/ready input stream and distributes the words across 2**SIZE_CTRL registered output lanes. It generates the demux select (`ctrl`) and owns a one-word holding register per lane, so each downstream consumer sees a standard valid/ready interface. It sits between a single producer and N consumers that share the producer's bandwidth.

## Interface
- `SIZE_CTRL`, default 2: select width. Lane count N = 2**SIZE_CTRL.
- `WIRE`, default 8: data word width.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `mode`  in  1: 0 = strict round-robin, 1 = skip-busy round-robin.
- `in_valid`  in  1: producer has a word.
- `in_data`  in  WIRE: producer word.
- `in_ready`  out  1: scheduler accepts `in_data` this cycle.
- `ctrl`  out  SIZE_CTRL: lane selected this cycle (demux select, combinational).
- `out_data`  out  N*WIRE: lane i occupies bits [i*WIRE +: WIRE].
- `out_valid`  out  N: lane i holds a word.
- `out_ready`  in  N: consumer i takes its word this cycle.
- `xfer_cnt`  out  16: count of accepted input words, wraps modulo 2**16.

## Operation
- State:
  - pointer `ptr` (SIZE_CTRL bits)
  - per-lane `out_valid[i]` and `out_data` slice
  - `xfer_cnt`
- Lane free: `free[i]` = !out_valid[i] | out_ready[i]. A lane that is being drained this cycle counts as free, so full throughput is possible.
- Lane selection in strict mode (`mode`=0):
  - `sel` = ptr.
  - `in_ready` = free[ptr].
  - A busy lane stalls the producer. Lanes are never skipped.
- Lane selection in skip mode (`mode`=1):
  - `sel` = the first free lane found by searching ptr, ptr+1, … N-1, 0, … ptr-1, with modular wrap.
  - `in_ready` = |free.
  - If no lane is free, `sel` = ptr.
- `ctrl` = sel at all times.
- Accept occurs when in_valid & in_ready:
  - out_data slice[sel] <= in_data.
  - out_valid[sel] <= 1.
  - ptr <= (sel+1) mod N.
  - xfer_cnt <= xfer_cnt+1.
- Drain: for every lane i ≠ (accepted sel), out_valid[i] & out_ready[i] clears out_valid[i]. The data slice holds its value.
- Simultaneous drain and load on the same lane: the load wins. out_valid stays 1 and the new data is presented the next cycle.
- No accept: ptr and xfer_cnt hold.
- `mode` may change on any cycle. It affects only the current cycle's `sel` and `in_ready`. ptr is not altered by a mode change.
- `in_ready` does not depend on `in_valid`, so there is no combinational loop with the producer.

## Timing
- Reset (async, takes effect immediately): ptr=0, out_valid=0, out_data=0, xfer_cnt=0. Consequently ctrl=0 and in_ready=1 in both modes.
- Latency: a word accepted at edge k appears on out_valid/out_data after edge k. That is 1 cycle.
- Throughput: 1 word/cycle while the selected lane is free.
- Back-to-back accepts visit lanes 0,1,…,N-1,0 (wrap) when all lanes are free.
- `in_ready`, `ctrl` and `sel` are combinational from the registers, `mode` and `out_ready`.
- Reset asserted mid-transfer: all held words are discarded and out_valid drops immediately. After release, the first word goes to lane 0.
- xfer_cnt 0xFFFF + accept → 0x0000.

## Test plan
All scenarios use SIZE_CTRL=2, WIRE=8.
- **Reset:** assert reset, then release with out_ready=4'b1111 and in_valid=0 → out_valid=0, out_data=0, ctrl=0, in_ready=1, xfer_cnt=0.
- **Round robin:** strict mode, out_ready=4'b1111, stream 0xA0,0xA1,0xA2,0xA3,0xA4 on consecutive cycles → each lands in lanes 0,1,2,3,0 one cycle after accept. ctrl sequence 0,1,2,3,0. xfer_cnt=5.
- **Strict stall:** strict mode, lane 1 full with out_ready[1]=0, ptr=1 → in_ready=0 and ctrl=1 for 3 cycles. Raise out_ready[1] → the same cycle in_ready=1, the word loads into lane 1 and out_valid[1] stays 1.
- **Skip mode:** mode=1, lanes 1 and 2 full and not ready, ptr=1, in_data=0x55 → ctrl=3, 0x55 lands in lane 3, ptr becomes 0. With all four lanes full and not ready → in_ready=0.
- **Simultaneous load/drain:** lane 0 holds 0x11, out_ready[0]=1, and 0x22 is accepted into lane 0 in the same cycle → next cycle out_valid[0]=1 and lane 0 data=0x22.
- **Reset mid-operation and counter wrap:**
  - Assert reset while lanes 0–2 are valid → all out_valid=0 without waiting for a clock edge. The next accepted word lands in lane 0.
  - Separately, force 65536 accepts → xfer_cnt=0.

Source files
------------

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler for the demux datapath.
// One valid/ready producer stream is spread across 2**SIZE_CTRL registered
// output lanes. Each lane has a one-word holding register. The scheduler
// drives the demux select (ctrl) and a valid/ready handshake toward each consumer.
module demux_rr_sched #(
    parameter int SIZE_CTRL = 2,
    parameter int WIRE      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mode,
    input  logic                            in_valid,
    input  logic [WIRE-1:0]                 in_data,
    output logic                            in_ready,
    output logic [SIZE_CTRL-1:0]            ctrl,
    output logic [(2**SIZE_CTRL)*WIRE-1:0]  out_data,
    output logic [(2**SIZE_CTRL)-1:0]       out_valid,
    input  logic [(2**SIZE_CTRL)-1:0]       out_ready,
    output logic [15:0]                     xfer_cnt
);

    localparam int N = 2**SIZE_CTRL;

    logic [SIZE_CTRL-1:0] ptr;
    logic [SIZE_CTRL-1:0] sel;
    logic [SIZE_CTRL-1:0] idx;
    logic                 found;
    logic [N-1:0]         free;
    logic                 accept;

    // A lane is free when it is empty or its consumer drains it this cycle.
    always_comb begin
        free = ~out_valid | out_ready;
    end

    // Lane selection: strict uses ptr; skip searches upward from ptr with wrap.
    always_comb begin
        sel   = ptr;
        idx   = ptr;
        found = 1'b0;
        if (mode) begin
            for (int k = 0; k < N; k++) begin
                idx = ptr + SIZE_CTRL'(k);
                if (!found && free[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
    end

    // Ready depends only on registered state, mode and out_ready, never on in_valid.
    always_comb begin
        in_ready = mode ? (|free) : free[ptr];
        ctrl     = sel;
        accept   = in_valid & in_ready;
    end

    // Lane registers: a load into a lane overrides a drain of that lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept && (sel == SIZE_CTRL'(i))) begin
                    out_valid[i]                <= 1'b1;
                    out_data[i*WIRE +: WIRE]    <= in_data;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i]                <= 1'b0;
                end
            end
        end
    end

    // Pointer advances past the lane just loaded. The counter counts accepts modulo 2**16.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            xfer_cnt <= '0;
        end else if (accept) begin
            ptr      <= sel + SIZE_CTRL'(1);
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule
